// File: rtl/inert_cmd_seq.sv
// ---------------------------------------------------------------------------
// inert_cmd_seq
//
// Command sequencer in front of the SPI monarch for the inertial sensor.
// After a power-up delay it issues three configuration writes. It then
// services each data-ready interrupt with a low-byte read followed by a
// high-byte read. The assembled 16-bit yaw rate is presented with a
// one-cycle valid strobe.
//
// Handshake with the SPI monarch: snd is a one-cycle request pulse, and cmd
// is held stable from snd onwards. done is a level that the monarch drops
// after snd and raises when the transaction ends, with resp valid from that
// point. Only a rising edge of done (done & ~done_q) counts as completion, so
// a done level left high from the previous transaction is never taken as a
// new completion. A new snd is only issued after the outstanding transaction
// has completed.
//
// Optional build macro YAW_AVG_EN: when defined, four consecutive samples
// are summed in an 18-bit signed accumulator and yaw_rt takes the
// arithmetic-shifted mean, with vld asserted once per four read pairs.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   INT          sensor data-ready (asynchronous, level-high)
//   done, resp   SPI completion level and response word
//   snd, cmd     SPI request pulse and command word
//   yaw_rt, vld  assembled yaw rate and its one-cycle update strobe
//   init_cmplt   sticky flag, set once the configuration writes are done
//   dbg_state    current FSM state, for observation only
// ---------------------------------------------------------------------------
module inert_cmd_seq #(
  parameter int          PWRUP_BITS = 16,
  parameter logic [15:0] INIT0      = 16'h0D02,
  parameter logic [15:0] INIT1      = 16'h1160,
  parameter logic [15:0] INIT2      = 16'h1440,
  parameter logic [15:0] RD_L       = 16'hA600,
  parameter logic [15:0] RD_H       = 16'hA700
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        snd,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_cmplt,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    PWRUP = 4'd0,
    W0    = 4'd1,
    W0_WT = 4'd2,
    W1    = 4'd3,
    W1_WT = 4'd4,
    W2    = 4'd5,
    W2_WT = 4'd6,
    IDLE  = 4'd7,
    RL    = 4'd8,
    RL_WT = 4'd9,
    RH    = 4'd10,
    RH_WT = 4'd11
  } state_t;

  state_t                state_q, state_d;
  logic [PWRUP_BITS-1:0] tmr_q, tmr_d;
  logic                  int_meta_q, int_s_q;
  logic                  done_q;
  logic                  snd_q, snd_d;
  logic [15:0]           cmd_q, cmd_d;
  logic [7:0]            yaw_l_q, yaw_l_d;
  logic [15:0]           yaw_rt_q, yaw_rt_d;
  logic                  vld_q, vld_d;
  logic                  init_q, init_d;
  logic                  done_rise;
  logic [15:0]           sample;

`ifdef YAW_AVG_EN
  logic signed [17:0]    acc_q, acc_d;
  logic [1:0]            cnt_q, cnt_d;
  logic signed [17:0]    sum;
`endif

  // Only the low byte of each read response carries data.
  logic unused_resp_hi;
  assign unused_resp_hi = &{1'b0, resp[15:8]};

  assign done_rise = done & ~done_q;
  assign sample    = {resp[7:0], yaw_l_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PWRUP;
      tmr_q      <= '0;
      int_meta_q <= 1'b0;
      int_s_q    <= 1'b0;
      done_q     <= 1'b0;
      snd_q      <= 1'b0;
      cmd_q      <= '0;
      yaw_l_q    <= '0;
      yaw_rt_q   <= '0;
      vld_q      <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      int_meta_q <= INT;
      int_s_q    <= int_meta_q;
      done_q     <= done;
      snd_q      <= snd_d;
      cmd_q      <= cmd_d;
      yaw_l_q    <= yaw_l_d;
      yaw_rt_q   <= yaw_rt_d;
      vld_q      <= vld_d;
      init_q     <= init_d;
    end
  end

`ifdef YAW_AVG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
`endif

  // snd and cmd are registered on the transition into a send state, so the
  // pulse coincides with the cycle the FSM spends in W0/W1/W2/RL/RH.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    snd_d    = 1'b0;
    cmd_d    = cmd_q;
    yaw_l_d  = yaw_l_q;
    yaw_rt_d = yaw_rt_q;
    vld_d    = 1'b0;
    init_d   = init_q;
`ifdef YAW_AVG_EN
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sum      = acc_q + {{2{sample[15]}}, sample};
`endif

    // The timer is only cleared by reset; it simply stops counting once
    // the FSM has left PWRUP.
    if (state_q == PWRUP) tmr_d = tmr_q + 1'b1;

    case (state_q)
      PWRUP: if (&tmr_q) begin
        state_d = W0;
        snd_d   = 1'b1;
        cmd_d   = INIT0;
      end
      W0: state_d = W0_WT;
      W0_WT: if (done_rise) begin
        state_d = W1;
        snd_d   = 1'b1;
        cmd_d   = INIT1;
      end
      W1: state_d = W1_WT;
      W1_WT: if (done_rise) begin
        state_d = W2;
        snd_d   = 1'b1;
        cmd_d   = INIT2;
      end
      W2: state_d = W2_WT;
      W2_WT: if (done_rise) begin
        state_d = IDLE;
        init_d  = 1'b1;
      end
      IDLE: if (int_s_q) begin
        state_d = RL;
        snd_d   = 1'b1;
        cmd_d   = RD_L;
      end
      RL: state_d = RL_WT;
      RL_WT: if (done_rise) begin
        state_d = RH;
        snd_d   = 1'b1;
        cmd_d   = RD_H;
        yaw_l_d = resp[7:0];
      end
      RH: state_d = RH_WT;
      RH_WT: if (done_rise) begin
        state_d = IDLE;
`ifdef YAW_AVG_EN
        // sum[17:2] is sum >>> 2 truncated to 16 bits (rounds toward -inf).
        if (cnt_q == 2'd3) begin
          yaw_rt_d = sum[17:2];
          vld_d    = 1'b1;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + 2'd1;
        end
`else
        yaw_rt_d = sample;
        vld_d    = 1'b1;
`endif
      end
      default: state_d = PWRUP;
    endcase
  end

  assign snd        = snd_q;
  assign cmd        = cmd_q;
  assign yaw_rt     = yaw_rt_q;
  assign vld        = vld_q;
  assign init_cmplt = init_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_inert_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_inert_cmd_seq
//
// Directed bench for inert_cmd_seq with a 4-bit power-up timer. An SPI
// responder process answers every snd 40 cycles later with done and a
// response word, checks the issued commands against an expected queue, and
// checks snd/vld pulse widths, the vld and init_cmplt latency and that no
// snd overlaps an outstanding transaction. The main sequence covers
// power-up, configuration, ignored INT, stale done, yaw reads (or averaging
// under YAW_AVG_EN) and reset in the middle of a read.
// Cycle numbering for the power-up delay: the first clock edge after reset
// release is cycle 0.
// ---------------------------------------------------------------------------
module tb_inert_cmd_seq;

  localparam logic [15:0] C_INIT0 = 16'h0D02;
  localparam logic [15:0] C_INIT1 = 16'h1160;
  localparam logic [15:0] C_INIT2 = 16'h1440;
  localparam logic [15:0] C_RD_L  = 16'hA600;
  localparam logic [15:0] C_RD_H  = 16'hA700;
  localparam int          LAT     = 40;
  localparam int          S_PWRUP = 0;
  localparam int          S_IDLE  = 7;
  localparam int          S_RH_WT = 11;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   edge_cnt = 0;
  initial forever #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic        int_in = 1'b0;
  logic        done = 1'b0;
  logic [15:0] resp = 16'h0;
  logic        snd, vld, init_cmplt;
  logic [15:0] cmd, yaw_rt;
  logic [3:0]  dbg_state;

  inert_cmd_seq #(.PWRUP_BITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .INT        (int_in),
    .done       (done),
    .resp       (resp),
    .snd        (snd),
    .cmd        (cmd),
    .yaw_rt     (yaw_rt),
    .vld        (vld),
    .init_cmplt (init_cmplt),
    .dbg_state  (dbg_state)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_snd = 0, n_done = 0, n_vld = 0;
  int last_snd_edge = 0, done_edge = 0;
  logic [15:0] vld_val = 16'h0;
  logic [15:0] resp_l = 16'h0, resp_h = 16'h0;
  int rel_edge = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // SPI responder and monitors, sampling on the falling edge
  initial begin : spi_model
    int          cnt;
    logic        busy, snd_prev, vld_prev, init_prev;
    logic [15:0] last_cmd, exp_cmd;
    cnt = 0; busy = 1'b0; snd_prev = 1'b0; vld_prev = 1'b0; init_prev = 1'b0;
    last_cmd = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0; busy = 1'b0; done = 1'b0;
        snd_prev = 1'b0; vld_prev = 1'b0; init_prev = 1'b0;
        continue;
      end
      if (snd) begin
        n_snd++;
        last_snd_edge = edge_cnt;
        check("snd_while_busy", 32'(busy), 32'd0);
        check("snd_width", 32'(snd_prev), 32'd0);
        check("snd_expected", 32'(exp_q.size() == 0), 32'd0);
        if (exp_q.size() > 0) begin
          exp_cmd = exp_q.pop_front();
          check("cmd", 32'(cmd), 32'(exp_cmd));
        end
        last_cmd = cmd;
        busy = 1'b1;
        cnt = LAT;
        done = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy = 1'b0;
          done = 1'b1;
          resp = (last_cmd == C_RD_L) ? resp_l : (last_cmd == C_RD_H) ? resp_h : 16'h0;
          n_done++;
          done_edge = edge_cnt;
        end
      end
      if (vld) begin
        n_vld++;
        vld_val = yaw_rt;
        check("vld_width", 32'(vld_prev), 32'd0);
        check("vld_latency", 32'(edge_cnt - done_edge), 32'd1);
        check("vld_after_rdh", 32'(last_cmd), 32'(C_RD_H));
      end
      if (init_cmplt && !init_prev) begin
        check("init_latency", 32'(edge_cnt - done_edge), 32'd1);
        check("init_after_3_done", 32'(n_done), 32'd3);
      end
      snd_prev = snd;
      vld_prev = vld;
      init_prev = init_cmplt;
    end
  end

  task automatic wait_snd(input int target, input int bound, input string tag);
    int i = 0;
    while (n_snd < target && i < bound) begin
      tick();
      i++;
    end
    check(tag, 32'(n_snd >= target), 32'd1);
  endtask

  task automatic wait_done(input int target, input int bound, input string tag);
    int i = 0;
    while (n_done < target && i < bound) begin
      tick();
      i++;
    end
    check(tag, 32'(n_done >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_snd"}, 32'(snd), 32'd0);
    check({tag, "_cmd"}, 32'(cmd), 32'd0);
    check({tag, "_yaw"}, 32'(yaw_rt), 32'd0);
    check({tag, "_vld"}, 32'(vld), 32'd0);
    check({tag, "_init"}, 32'(init_cmplt), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_PWRUP));
  endtask

  // One interrupt-driven read pair; INT is dropped once the high-byte read
  // has been issued, as the sensor clears it on being read.
  task automatic read_pair(input logic [15:0] lo, input logic [15:0] hi);
    int sb, db;
    sb = n_snd;
    db = n_done;
    resp_l = lo;
    resp_h = hi;
    exp_q.push_back(C_RD_L);
    exp_q.push_back(C_RD_H);
    int_in = 1'b1;
    wait_snd(sb + 2, 200, "rd_snd_timeout");
    int_in = 1'b0;
    wait_done(db + 2, 100, "rd_done_timeout");
    repeat (3) tick();
  endtask

  initial begin : main
    int vb;
    #100000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin : stim
    int sb;
    // Test 1: reset state and power-up delay
    repeat (3) tick();
    check_reset_outputs("rst");
    exp_q.push_back(C_INIT0);
    exp_q.push_back(C_INIT1);
    exp_q.push_back(C_INIT2);
    rst_n = 1'b1;
    rel_edge = edge_cnt;
    wait_snd(1, 100, "t1_snd_timeout");
    check("t1_first_snd_cycle", 32'(last_snd_edge - rel_edge - 1), 32'd15);
    check("t1_cmd", 32'(cmd), 32'(C_INIT0));
    check("t1_no_init_yet", 32'(init_cmplt), 32'd0);

    // Test 2 + 4a: configuration writes, INT pulse during W1_WT ignored
    wait_snd(2, 100, "t2_snd2_timeout");
    repeat (3) tick();
    int_in = 1'b1;
    repeat (4) tick();
    int_in = 1'b0;
    wait_snd(3, 100, "t2_snd3_timeout");
    check("t2_init_before_3rd_done", 32'(init_cmplt), 32'd0);
    wait_done(3, 100, "t2_done3_timeout");
    tick();
    check("t2_init_cmplt", 32'(init_cmplt), 32'd1);
    check("t2_snd_count", 32'(n_snd), 32'd3);
    check("t2_vld_count", 32'(n_vld), 32'd0);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Test 4b: done left high in IDLE with INT low
    repeat (60) tick();
    check("t4_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("t4_no_snd", 32'(n_snd), 32'd3);
    check("t4_no_vld", 32'(n_vld), 32'd0);
    check("t4_init_sticky", 32'(init_cmplt), 32'd1);

`ifdef YAW_AVG_EN
    // Test 6: four samples averaged into one strobe
    read_pair(16'h0010, 16'h0000);
    read_pair(16'h0020, 16'h0000);
    read_pair(16'h00F0, 16'h00FF);
    check("t6_no_vld_after_3", 32'(n_vld), 32'd0);
    check("t6_yaw_held", 32'(yaw_rt), 32'd0);
    read_pair(16'h0004, 16'h0000);
    check("t6_one_vld", 32'(n_vld), 32'd1);
    check("t6_avg", 32'(vld_val), 32'h0009);
    check("t6_yaw_rt", 32'(yaw_rt), 32'h0009);
`else
    // Test 3: yaw read pair
    read_pair(16'h00A5, 16'h00FF);
    check("t3_vld_count", 32'(n_vld), 32'd1);
    check("t3_vld_value", 32'(vld_val), 32'hFFA5);
    check("t3_snd_count", 32'(n_snd), 32'd5);
    repeat (30) tick();
    check("t3_yaw_held", 32'(yaw_rt), 32'hFFA5);
    check("t3_no_extra_read", 32'(n_snd), 32'd5);
    // upper response bytes must be discarded
    read_pair(16'hBE34, 16'hCD80);
    check("t3b_vld_count", 32'(n_vld), 32'd2);
    check("t3b_vld_value", 32'(vld_val), 32'h8034);
    check("t3b_yaw_rt", 32'(yaw_rt), 32'h8034);
`endif

    // Test 5: reset in the middle of the high-byte read
    sb = n_snd;
    resp_l = 16'h0011;
    resp_h = 16'h0022;
    exp_q.push_back(C_RD_L);
    exp_q.push_back(C_RD_H);
    int_in = 1'b1;
    wait_snd(sb + 2, 200, "t5_snd_timeout");
    int_in = 1'b0;
    repeat (10) tick();
    check("t5_in_rh_wt", 32'(dbg_state), 32'(S_RH_WT));
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    check_reset_outputs("t5_rst");
    repeat (2) tick();
    exp_q.push_back(C_INIT0);
    sb = n_snd;
    rst_n = 1'b1;
    rel_edge = edge_cnt;
    repeat (10) tick();
    check("t5_no_early_snd", 32'(n_snd), 32'(sb));
    wait_snd(sb + 1, 100, "t5_snd_timeout2");
    check("t5_first_snd_cycle", 32'(last_snd_edge - rel_edge - 1), 32'd15);
    check("t5_cmd", 32'(cmd), 32'(C_INIT0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
